// File: rtl/alu_mdu_if.sv
// alu_mdu_if: operand/result handshake bundle for the execute-stage ALU/MDU.
// Ports: in_valid/in_ready with A, B, ALUop, in_tag on the request side;
// out_valid/out_ready with out, out_zero, out_err, out_tag on the result side.
interface alu_mdu_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUop;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_zero;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  // Issuing side: drives operands and consumes results.
  modport master (
    output in_valid, A, B, ALUop, in_tag, out_ready,
    input  in_ready, out_valid, out, out_zero, out_err, out_tag
  );

  // ALU/MDU side.
  modport slave (
    input  in_valid, A, B, ALUop, in_tag, out_ready,
    output in_ready, out_valid, out, out_zero, out_err, out_tag
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: registered integer ALU with iterative unsigned multiply/divide.
// Latency: single-cycle ops 1 edge after accept; MULU/MULHU/DIVU/REMU WIDTH+1 edges.
// Backpressure: result held while out_ready=0; in_ready = idle, or done & out_ready.
// Ports: clk, rst (synchronous, active high), bus (alu_mdu_if.slave).
// Build option: define ALU_MDU_DIV_EN to include the iterative divider; without it
// DIVU/REMU finish in one cycle with out=0 and out_err=1.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_mdu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;       // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor
  logic               hi_sel;    // result from upper half (MULHU/REMU)
`ifdef ALU_MDU_DIV_EN
  logic               is_div;
`endif

  logic [WIDTH-1:0]   out_q;
  logic [TAG_W-1:0]   tag_q;
  logic               zero_q;
  logic               err_q;
  logic               valid_q;

  logic               accept;
  logic               is_mdu;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_err;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mdu_res;
  logic [WIDTH:0]     add_sum;
`ifdef ALU_MDU_DIV_EN
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
`endif

  // Reset forces in_ready low so a request presented during reset is never taken.
  assign bus.in_ready  = !rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_err   = err_q;
  assign bus.out_tag   = tag_q;

`ifdef ALU_MDU_DIV_EN
  assign is_mdu = (bus.ALUop[3:2] == 2'b11);
  assign sc_err = 1'b0;
`else
  assign is_mdu = (bus.ALUop[3:1] == 3'b110);
  assign sc_err = (bus.ALUop[3:1] == 3'b111);
`endif

  assign shamt = bus.A[SHW-1:0];

  always_comb begin
    sc_res = '0;
    case (bus.ALUop)
      4'b0000: sc_res = bus.A + bus.B;
      4'b0001: sc_res = bus.A - bus.B;
      4'b0010: sc_res = bus.A & bus.B;
      4'b0011: sc_res = bus.A | bus.B;
      4'b0100: sc_res = bus.A ^ bus.B;
      4'b0101: sc_res = ~(bus.A | bus.B);
      4'b0110: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      4'b0111: sc_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'b1000: sc_res = bus.B << shamt;
      4'b1001: sc_res = bus.B >> shamt;
      4'b1010: sc_res = $unsigned($signed(bus.B) >>> shamt);
      4'b1011: sc_res = bus.B << (WIDTH/2);
      default: sc_res = '0;   // MDU ops, or disabled divide
    endcase
  end

  // One iteration step. Multiply: add multiplicand when the multiplier LSB is
  // set, then shift the whole product right. Divide: shift the next dividend
  // bit into the remainder and subtract if it fits (restoring).
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    acc_nxt = {add_sum, acc[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      // A zero divisor always "fits", giving all-ones quotient and remainder = A.
      if (!diff[WIDTH])
        acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
`endif
  end

  assign mdu_res = hi_sel ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      hi_sel  <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      is_div  <= 1'b0;
`endif
      out_q   <= '0;
      tag_q   <= '0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (accept) begin
      tag_q <= bus.in_tag;
      if (is_mdu) begin
        state   <= BUSY;
        cnt     <= '0;
        valid_q <= 1'b0;
        hi_sel  <= bus.ALUop[0];
        // ALUop[1] set = divide: dividend in the low half, divisor aside.
        opnd    <= bus.ALUop[1] ? bus.B : bus.A;
        acc     <= {{WIDTH{1'b0}}, (bus.ALUop[1] ? bus.A : bus.B)};
`ifdef ALU_MDU_DIV_EN
        is_div  <= bus.ALUop[1];
`endif
      end else begin
        state   <= DONE;
        valid_q <= 1'b1;
        out_q   <= sc_res;
        zero_q  <= (sc_res == '0);
        err_q   <= sc_err;
      end
    end else begin
      case (state)
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH-1)) begin
            state   <= DONE;
            valid_q <= 1'b1;
            out_q   <= mdu_res;
            zero_q  <= (mdu_res == '0);
            err_q   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu (WIDTH=32, TAG_W=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_mdu;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_mdu_if #(.WIDTH(32), .TAG_W(4)) bus ();

  alu_mdu #(.WIDTH(32), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [3:0] tag);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.ALUop    = op;
    bus.in_tag   = tag;
  endtask

  // Counts edges from the accepting edge until out_valid, bounded; flags any
  // cycle in between where in_ready was not low.
  task automatic wait_result(output int edges, output bit busy_bad);
    edges    = 1;
    busy_bad = 1'b0;
    while (bus.out_valid !== 1'b1 && edges < 200) begin
      if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'd5, 32'd6, 4'b0000, 4'd9);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    tick();
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL rst_out: got %h expected 0", bus.out); end
    n_checks++; if (bus.out_zero !== 1'b1) begin n_fail++; $display("FAIL rst_out_zero: got %b expected 1", bus.out_zero); end
    n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err: got %b expected 0", bus.out_err); end
    n_checks++; if (bus.out_tag !== 4'd0) begin n_fail++; $display("FAIL rst_out_tag: got %h expected 0", bus.out_tag); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_add();
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 4'd3);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.out !== 32'h0) begin n_fail++; $display("FAIL add_out: got %h expected 00000000", bus.out); end
    n_checks++; if (bus.out_zero !== 1'b1) begin n_fail++; $display("FAIL add_zero: got %b expected 1", bus.out_zero); end
    n_checks++; if (bus.out_tag !== 4'd3) begin n_fail++; $display("FAIL add_tag: got %h expected 3", bus.out_tag); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_ops();
    vec_t v[13] = '{
      '{4'b0001, 32'd5,         32'd7,         32'hFFFF_FFFE},
      '{4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
      '{4'b0011, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0},
      '{4'b0100, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00},
      '{4'b0101, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000},
      '{4'b0110, 32'd1,         32'hFFFF_FFFF, 32'h0000_0000},
      '{4'b0111, 32'd1,         32'h8000_0000, 32'h0000_0001},
      '{4'b0111, 32'h8000_0000, 32'd1,         32'h0000_0000},
      '{4'b1000, 32'h24,        32'd1,         32'h0000_0010},
      '{4'b1001, 32'hFF,        32'h8000_0000, 32'h0000_0001},
      '{4'b1010, 32'd1,         32'h7FFF_FFFE, 32'h3FFF_FFFF},
      '{4'b1011, 32'hFFFF_FFFF, 32'h0000_1234, 32'h1234_0000},
      '{4'b0000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000}
    };
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, v[i].a, v[i].b, v[i].op, 4'(i));
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out !== v[i].exp || bus.out_zero !== (v[i].exp == 32'h0) || bus.out_valid !== 1'b1)
        begin n_fail++; $display("FAIL op_%0d (ALUop %b): got out=%h zero=%b valid=%b expected out=%h zero=%b valid=1",
                                 i, v[i].op, bus.out, bus.out_zero, bus.out_valid, v[i].exp, (v[i].exp == 32'h0)); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'd1, 4'b0110, 4'd1);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b expected 1", bus.in_ready); end
    tick();
    drive(1'b1, 32'd4, 32'hF000_0000, 4'b1010, 4'd2);
    n_checks++; if (bus.out !== 32'd1 || bus.out_tag !== 4'd1 || bus.out_valid !== 1'b1)
      begin n_fail++; $display("FAIL b2b_slt: got out=%h tag=%h valid=%b expected out=00000001 tag=1 valid=1", bus.out, bus.out_tag, bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b expected 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out !== 32'hFF00_0000 || bus.out_tag !== 4'd2 || bus.out_valid !== 1'b1)
      begin n_fail++; $display("FAIL b2b_sra: got out=%h tag=%h valid=%b expected out=ff000000 tag=2 valid=1", bus.out, bus.out_tag, bus.out_valid); end
    tick();
  endtask

  task automatic test_mul();
    int edges;
    bit busy_bad;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, 4'd5);
    tick();
    bus.in_valid = 1'b0;
    wait_result(edges, busy_bad);
    n_checks++; if (edges !== 33) begin n_fail++; $display("FAIL mulhu_latency: got %0d edges expected 33", edges); end
    n_checks++; if (busy_bad) begin n_fail++; $display("FAIL mulhu_busy_ready: got in_ready high while busy expected 0"); end
    n_checks++; if (bus.out !== 32'hFFFF_FFFE || bus.out_tag !== 4'd5)
      begin n_fail++; $display("FAIL mulhu_out: got out=%h tag=%h expected out=fffffffe tag=5", bus.out, bus.out_tag); end
    // Next op accepted straight out of DONE.
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 4'd6);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mulu_ready: got %b expected 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    wait_result(edges, busy_bad);
    n_checks++; if (edges !== 33 || bus.out !== 32'h1 || bus.out_zero !== 1'b0)
      begin n_fail++; $display("FAIL mulu_out: got out=%h zero=%b edges=%0d expected out=00000001 zero=0 edges=33", bus.out, bus.out_zero, edges); end
    drive(1'b1, 32'd12345, 32'd0, 4'b1100, 4'd7);
    tick();
    bus.in_valid = 1'b0;
    wait_result(edges, busy_bad);
    n_checks++; if (bus.out !== 32'h0 || bus.out_zero !== 1'b1)
      begin n_fail++; $display("FAIL mulu_zero: got out=%h zero=%b expected out=00000000 zero=1", bus.out, bus.out_zero); end
    tick();
  endtask

`ifdef ALU_MDU_DIV_EN
  task automatic test_div();
    int edges;
    bit busy_bad;
    bit hold_bad;
    vec_t v[3] = '{
      '{4'b1111, 32'd100,       32'd7, 32'd2},
      '{4'b1110, 32'd100,       32'd0, 32'hFFFF_FFFF},
      '{4'b1111, 32'h1234_5678, 32'd0, 32'h1234_5678}
    };
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd100, 32'd7, 4'b1110, 4'd8);
    tick();
    bus.in_valid = 1'b0;
    wait_result(edges, busy_bad);
    n_checks++; if (edges !== 33 || bus.out !== 32'd14 || bus.out_err !== 1'b0)
      begin n_fail++; $display("FAIL divu_out: got out=%h err=%b edges=%0d expected out=0000000e err=0 edges=33", bus.out, bus.out_err, edges); end
    hold_bad = 1'b0;
    drive(1'b1, 32'd1, 32'd1, 4'b0000, 4'd9);
    for (int i = 0; i < 4; i++) begin
      if (bus.in_ready !== 1'b0 || bus.out !== 32'd14 || bus.out_valid !== 1'b1 || bus.out_tag !== 4'd8) hold_bad = 1'b1;
      tick();
    end
    n_checks++; if (hold_bad) begin n_fail++; $display("FAIL divu_hold: got result change or in_ready high under backpressure expected stable 0000000e"); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL divu_drain: got %b expected 0", bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, v[i].a, v[i].b, v[i].op, 4'(i));
      tick();
      bus.in_valid = 1'b0;
      wait_result(edges, busy_bad);
      n_checks++; if (edges !== 33 || bus.out !== v[i].exp || bus.out_err !== 1'b0)
        begin n_fail++; $display("FAIL div_%0d: got out=%h err=%b edges=%0d expected out=%h err=0 edges=33", i, bus.out, bus.out_err, edges, v[i].exp); end
      tick();
    end
  endtask
`else
  task automatic test_div();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'd100, 32'd7, 4'b1110, 4'd8);
    tick();
    drive(1'b1, 32'd100, 32'd7, 4'b1111, 4'd9);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out !== 32'h0 || bus.out_zero !== 1'b1 || bus.out_err !== 1'b1)
      begin n_fail++; $display("FAIL divu_off: got valid=%b out=%h zero=%b err=%b expected valid=1 out=00000000 zero=1 err=1",
                               bus.out_valid, bus.out, bus.out_zero, bus.out_err); end
    tick();
    drive(1'b1, 32'd1, 32'd1, 4'b0000, 4'd10);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_tag !== 4'd9)
      begin n_fail++; $display("FAIL remu_off: got valid=%b err=%b tag=%h expected valid=1 err=1 tag=9", bus.out_valid, bus.out_err, bus.out_tag); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out !== 32'd2 || bus.out_err !== 1'b0)
      begin n_fail++; $display("FAIL add_err_off: got out=%h err=%b expected out=00000002 err=0", bus.out, bus.out_err); end
    tick();
  endtask
`endif

  task automatic test_reset_mid_busy();
    bit stray;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'd3, 32'd5, 4'b1100, 4'd4);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_rst_ready: got %b expected 0", bus.in_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 32'h0)
      begin n_fail++; $display("FAIL busy_rst_state: got valid=%b ready=%b out=%h expected valid=0 ready=1 out=00000000", bus.out_valid, bus.in_ready, bus.out); end
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) stray = 1'b1;
      tick();
    end
    n_checks++; if (stray) begin n_fail++; $display("FAIL busy_rst_abort: got out_valid after reset expected 0"); end
    drive(1'b1, 32'd2, 32'd3, 4'b0000, 4'd11);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out !== 32'd5 || bus.out_tag !== 4'd11)
      begin n_fail++; $display("FAIL post_rst_add: got valid=%b out=%h tag=%h expected valid=1 out=00000005 tag=b", bus.out_valid, bus.out, bus.out_tag); end
    tick();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALUop     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_mul();
    test_div();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the datapath's single-op combinational ALU. It has a registered output and a valid/ready handshake on both sides.
- Full integer op set, with ADD keeping encoding 4'b0000.
- Single-cycle ops complete 1 edge after accept.
- Iterative unsigned multiply and divide take WIDTH+1 edges.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid.

Parameters:
WIDTH, 32, operand/result width; power of 2, >= 8.
TAG_W, 4, width of the sideband tag carried from input to output unchanged.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand/op presented.
in_ready  output  1  block can accept this cycle.
A  input  WIDTH  operand A; low log2(WIDTH) bits are the shift amount for shifts.
B  input  WIDTH  operand B.
ALUop  input  4  operation select.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  result register holds a valid result.
out_ready  input  1  consumer takes result this cycle.
out  output  WIDTH  result.
out_zero  output  1  out == 0.
out_err  output  1  op unsupported in this build.
out_tag  output  TAG_W  tag of the accepted op.

Behaviour:
- Handshake rules:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Deliver occurs when out_valid & out_ready.
  - A, B, ALUop and in_tag are captured at accept; the block never re-reads the inputs afterwards.
- Ops (SHW = log2(WIDTH)):
  - 0000 ADD A+B; 0001 SUB A-B; 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
  - 0110 SLT (signed A<B ? 1 : 0); 0111 SLTU (unsigned).
  - 1000 SLL B<<A[SHW-1:0]; 1001 SRL; 1010 SRA (arithmetic).
  - 1011 LUI B<<(WIDTH/2).
  - 1100 MULU low WIDTH bits of A*B; 1101 MULHU high WIDTH bits.
  - 1110 DIVU quotient; 1111 REMU remainder.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
- States:
  - IDLE: out_valid=0, in_ready=1.
    - Accept of ops 0000-1011 -> DONE.
    - Accept of ops 1100-1111 -> BUSY, iteration counter := 0.
  - BUSY: in_ready=0, out_valid=0.
    - One iteration per cycle: shift-add multiply into a 2*WIDTH product, restoring divide.
    - Counter reaching WIDTH-1 -> DONE with result registered.
  - DONE: out_valid=1, in_ready=out_ready.
    - out_ready & in_valid: single-cycle op stays DONE with the new result; MDU op -> BUSY.
    - out_ready & !in_valid -> IDLE.
    - !out_ready: hold; out, out_tag, out_zero and out_err stay stable.
- Latency from accept edge to out_valid:
  - Single-cycle ops: 1 edge.
  - MDU ops: WIDTH+1 edges.
- Throughput: 1 single-cycle op per clock while out_ready stays high.
- Divide by zero: quotient = all ones; remainder = A; out_err=0; same latency as a normal divide.
- Shift amounts use only A[SHW-1:0]; upper bits of A are ignored.
- Reset:
  - Values: state=IDLE, counter=0, out=0, out_tag=0, out_zero=1, out_err=0, out_valid=0.
  - in_ready is 0 during any cycle in which rst=1.
  - Reset mid-BUSY aborts the operation; no result is produced.
  - in_valid in a reset cycle is ignored.
- out_zero is registered alongside out (it is never computed combinationally from downstream).

Optional Feature:
- Macro: ALU_MDU_DIV_EN.
- Defined: DIVU/REMU are executed iteratively as above.
- Undefined:
  - No divider datapath is synthesised.
  - Ops 1110/1111 complete as single-cycle ops (latency 1) with out=0, out_zero=1, out_err=1.
  - out_err is constant 0 for all other ops in both builds.

Test Plan:
- ADD after reset: A=32'hFFFF_FFFF, B=1, ALUop=0000, tag=3, out_ready=1 -> next edge out_valid=1, out=0, out_zero=1, out_tag=3.
- Back-to-back SLT then SRA at out_ready=1:
  - SLT A=32'h8000_0000, B=1 -> out=1.
  - SRA A=4, B=32'hF000_0000 -> out=32'hFF00_0000.
  - One result per cycle, in_ready never drops.
- MULHU A=B=32'hFFFF_FFFF:
  - in_ready=0 for 32 cycles.
  - out_valid exactly 33 edges after accept, out=32'hFFFF_FFFE.
  - MULU with the same operands -> out=1.
- Backpressure: DIVU A=100, B=7 with out_ready=0 -> out=14 held stable and in_ready=0 until out_ready=1. REMU -> 2. DIVU B=0 -> out=32'hFFFF_FFFF; REMU B=0 -> out=A.
- Reset mid-BUSY: assert rst at iteration 10 of a MULU -> following cycle out_valid=0, in_ready=1, out=0. A new ADD 2+3 returns 5 with latency 1.
- Build without ALU_MDU_DIV_EN: DIVU 100/7 -> latency 1, out=0, out_err=1. ADD in the same build -> out_err=0.
